// File: rtl/b_resolve_queue_pkg.sv
// Shared types for the in-order branch resolve queue: per-entry state,
// the entry record and the default geometry.
package b_pkg;

    localparam int BQ_DEPTH = 8;
    localparam int BQ_PC_W  = 32;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        PENDING  = 2'd1,
        RESOLVED = 2'd2
    } entry_state_t;

    typedef struct packed {
        entry_state_t         state;
        logic [BQ_PC_W-1:0]   pc;
        logic                 pred;
        logic                 taken;
    } bq_entry_t;

    // Only meaningful once the entry has been resolved.
    function automatic logic bq_is_mispredict(input bq_entry_t e);
        return e.taken != e.pred;
    endfunction

endpackage

// File: rtl/b_resolve_queue.sv
// In-order queue of in-flight conditional branches: allocated at fetch,
// resolved out of order by tag, retired in program order with a registered commit stage.
module b_resolve_queue
    import b_pkg::*;
#(
    parameter int DEPTH = BQ_DEPTH,
    parameter int TAG_W = $clog2(DEPTH),
    parameter int PC_W  = BQ_PC_W
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             alloc_valid,
    input  logic [PC_W-1:0]  alloc_pc,
    input  logic             alloc_pred,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,

    input  logic             res_valid,
    input  logic [TAG_W-1:0] res_tag,
    input  logic             res_taken,

    input  logic             commit_en,
    output logic             branch_commit,
    output logic [PC_W-1:0]  pc_head,
    output logic             direct_resolved,
    output logic             direct_mispredict,
    output logic [TAG_W:0]   count
);

    // Handshake: alloc_valid/alloc_ready form a valid/ready pair; an entry is
    // written at the rising edge where both are high. res_valid has no ready:
    // a resolve that does not hit a PENDING entry is silently dropped.

    bq_entry_t          r_entries [DEPTH];
    logic [TAG_W-1:0]   r_head;
    logic [TAG_W-1:0]   r_tail;
    logic [TAG_W:0]     r_count;

    logic               r_branch_commit;
    logic [PC_W-1:0]    r_pc_head;
    logic               r_direct_resolved;
    logic               r_direct_mispredict;

    bq_entry_t          w_head_entry;
    bq_entry_t          w_res_entry;
    logic               w_full;
    logic               w_retire;
    logic               w_retire_mp;
    logic               w_alloc_ready;
    logic               w_alloc_fire;
    logic               w_res_hit;
    logic [TAG_W-1:0]   w_head_inc;
    logic [TAG_W:0]     w_count_next;

    always_comb begin
        w_head_entry  = r_entries[r_head];
        w_res_entry   = r_entries[res_tag];
        w_full        = (r_count == (TAG_W+1)'(DEPTH));
        w_retire      = commit_en && (w_head_entry.state == RESOLVED);
        w_retire_mp   = w_retire && bq_is_mispredict(w_head_entry);
        // Full blocks allocation even when a retire frees a slot this cycle,
        // keeping alloc_ready independent of commit_en except through flush.
        w_alloc_ready = !w_full && !w_retire_mp;
        w_alloc_fire  = alloc_valid && w_alloc_ready;
        w_res_hit     = res_valid && (w_res_entry.state == PENDING) && !w_retire_mp;
        w_head_inc    = r_head + TAG_W'(1);
        w_count_next  = r_count + (TAG_W+1)'(w_alloc_fire) - (TAG_W+1)'(w_retire);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i] <= '0;
            end
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (w_retire_mp) begin
            // Wrong-path entries behind a mispredicted head are discarded.
            for (int i = 0; i < DEPTH; i++) begin
                r_entries[i].state <= FREE;
            end
            r_head  <= w_head_inc;
            r_tail  <= w_head_inc;
            r_count <= '0;
        end else begin
            if (w_alloc_fire) begin
                r_entries[r_tail].state <= PENDING;
                r_entries[r_tail].pc    <= BQ_PC_W'(alloc_pc);
                r_entries[r_tail].pred  <= alloc_pred;
                r_entries[r_tail].taken <= 1'b0;
                r_tail                  <= r_tail + TAG_W'(1);
            end
            if (w_res_hit) begin
                r_entries[res_tag].state <= RESOLVED;
                r_entries[res_tag].taken <= res_taken;
            end
            if (w_retire) begin
                r_entries[r_head].state <= FREE;
                r_head                  <= w_head_inc;
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_commit     <= 1'b0;
            r_pc_head           <= '0;
            r_direct_resolved   <= 1'b0;
            r_direct_mispredict <= 1'b0;
        end else begin
            r_branch_commit     <= w_retire;
            r_direct_mispredict <= w_retire_mp;
            if (w_retire) begin
                r_pc_head         <= PC_W'(w_head_entry.pc);
                r_direct_resolved <= w_head_entry.taken;
            end
        end
    end

    assign alloc_ready       = w_alloc_ready;
    assign alloc_tag         = r_tail;
    assign count             = r_count;
    assign branch_commit     = r_branch_commit;
    assign pc_head           = r_pc_head;
    assign direct_resolved   = r_direct_resolved;
    assign direct_mispredict = r_direct_mispredict;

endmodule

// File: tb/tb_b_resolve_queue.sv
// Bench for b_resolve_queue: directed scenarios plus random traffic, all
// checked against a program-order list model of the in-flight branches.
module tb_b_resolve_queue;

    localparam int DEPTH = 8;
    localparam int TAG_W = 3;
    localparam int PC_W  = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             alloc_valid = 1'b0;
    logic [PC_W-1:0]  alloc_pc = '0;
    logic             alloc_pred = 1'b0;
    logic             alloc_ready;
    logic [TAG_W-1:0] alloc_tag;
    logic             res_valid = 1'b0;
    logic [TAG_W-1:0] res_tag = '0;
    logic             res_taken = 1'b0;
    logic             commit_en = 1'b0;
    logic             branch_commit;
    logic [PC_W-1:0]  pc_head;
    logic             direct_resolved;
    logic             direct_mispredict;
    logic [TAG_W:0]   count;

    b_resolve_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_pc(alloc_pc), .alloc_pred(alloc_pred),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .res_valid(res_valid), .res_tag(res_tag), .res_taken(res_taken),
        .commit_en(commit_en), .branch_commit(branch_commit), .pc_head(pc_head),
        .direct_resolved(direct_resolved), .direct_mispredict(direct_mispredict),
        .count(count)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: in-flight branches in program order
    typedef struct {
        int         tag;
        logic [31:0] pc;
        bit         pred;
        bit         taken;
        bit         resolved;
    } m_entry_t;

    m_entry_t    mq[$];
    int          m_head;
    bit          m_bc, m_dr, m_dm;
    logic [31:0] m_pc;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_head = 0;
        m_bc = 0; m_dr = 0; m_dm = 0; m_pc = '0;
    endtask

    task automatic check_outputs();
        check("branch_commit", 64'(branch_commit), 64'(m_bc));
        check("pc_head", 64'(pc_head), 64'(m_pc));
        check("direct_resolved", 64'(direct_resolved), 64'(m_dr));
        check("direct_mispredict", 64'(direct_mispredict), 64'(m_dm));
        check("count", 64'(count), 64'(mq.size()));
    endtask

    // One clock: drive at negedge, check combinational outputs, update model at posedge.
    task automatic cycle(input bit av, input logic [31:0] apc, input bit apred,
                         input bit rv, input int rtag, input bit rtaken, input bit ce);
        bit retire, mp, exp_ready, fire;
        int new_tag;
        m_entry_t e;
        alloc_valid = av; alloc_pc = apc; alloc_pred = apred;
        res_valid = rv; res_tag = TAG_W'(rtag); res_taken = rtaken; commit_en = ce;
        #1;
        retire    = ce && mq.size() > 0 && mq[0].resolved;
        mp        = retire && (mq[0].taken != mq[0].pred);
        exp_ready = (mq.size() != DEPTH) && !mp;
        new_tag   = (m_head + mq.size()) % DEPTH;
        check("alloc_ready", 64'(alloc_ready), 64'(exp_ready));
        check("alloc_tag", 64'(alloc_tag), 64'(new_tag));
        fire = av && exp_ready;
        @(posedge clk);
        m_bc = retire;
        m_dm = mp;
        if (retire) begin
            m_pc = mq[0].pc;
            m_dr = mq[0].taken;
        end
        if (rv && !mp) begin
            foreach (mq[i]) begin
                if (mq[i].tag == rtag && !mq[i].resolved) begin
                    mq[i].resolved = 1;
                    mq[i].taken = rtaken;
                end
            end
        end
        if (retire) begin
            void'(mq.pop_front());
            m_head = (m_head + 1) % DEPTH;
        end
        if (mp) mq.delete();
        if (fire) begin
            e.tag = new_tag; e.pc = apc; e.pred = apred; e.taken = 0; e.resolved = 0;
            mq.push_back(e);
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle(input bit ce);
        cycle(0, 32'h0, 0, 0, 0, 0, ce);
    endtask

    task automatic do_reset();
        alloc_valid = 0; res_valid = 0; commit_en = 0;
        rst = 1;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        check_outputs();
        check("reset_tag", 64'(alloc_tag), 64'd0);
    endtask

    initial begin
        int rt;
        model_reset();
        @(negedge clk);
        do_reset();

        // single branch, correctly predicted
        cycle(1, 32'h100, 1, 0, 0, 0, 0);
        cycle(0, 32'h0, 0, 1, 0, 1, 1);
        check("t1_no_early_retire", 64'(branch_commit), 64'd0);
        idle(1);
        check("t1_commit", 64'(branch_commit), 64'd1);
        check("t1_pc", 64'(pc_head), 64'h100);
        check("t1_dir", 64'(direct_resolved), 64'd1);
        check("t1_mp", 64'(direct_mispredict), 64'd0);
        check("t1_count", 64'(count), 64'd0);
        idle(1);
        check("t1_pulse_end", 64'(branch_commit), 64'd0);
        check("t1_pc_hold", 64'(pc_head), 64'h100);

        // out-of-order resolution, in-order retirement
        do_reset();
        cycle(1, 32'h10, 0, 0, 0, 0, 1);
        cycle(1, 32'h20, 1, 0, 0, 0, 1);
        cycle(1, 32'h30, 0, 0, 0, 0, 1);
        cycle(0, 32'h0, 0, 1, 2, 0, 1);
        cycle(0, 32'h0, 0, 1, 1, 1, 1);
        check("t2_hold_before_head", 64'(branch_commit), 64'd0);
        cycle(0, 32'h0, 0, 1, 0, 0, 1);
        check("t2_hold_head_pending", 64'(branch_commit), 64'd0);
        idle(1);
        check("t2_pc0", 64'(pc_head), 64'h10);
        idle(1);
        check("t2_pc1", 64'(pc_head), 64'h20);
        idle(1);
        check("t2_pc2", 64'(pc_head), 64'h30);
        check("t2_commit2", 64'(branch_commit), 64'd1);

        // mispredicted head flushes younger entries
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1, 32'h200 + 32'(i * 4), 0, 0, 0, 0, 0);
        cycle(0, 32'h0, 0, 1, 0, 1, 0);
        cycle(1, 32'h300, 1, 0, 0, 0, 1);
        check("t3_mp", 64'(direct_mispredict), 64'd1);
        check("t3_pc", 64'(pc_head), 64'h200);
        check("t3_count", 64'(count), 64'd0);
        check("t3_next_tag", 64'(alloc_tag), 64'd1);

        // full queue and wrap
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 32'h400 + 32'(i), 1, 0, 0, 0, 0);
        check("t4_count_full", 64'(count), 64'd8);
        cycle(1, 32'h999, 1, 1, 0, 1, 0);
        check("t4_full_count", 64'(count), 64'd8);
        idle(1);
        check("t4_retire", 64'(branch_commit), 64'd1);
        #1;
        check("t4_ready", 64'(alloc_ready), 64'd1);
        check("t4_wrap_tag", 64'(alloc_tag), 64'd0);
        cycle(1, 32'h500, 0, 0, 0, 0, 0);

        // ignored resolves
        do_reset();
        cycle(1, 32'h600, 1, 1, 3, 1, 0);
        cycle(0, 32'h0, 0, 1, 0, 0, 0);
        cycle(0, 32'h0, 0, 1, 0, 1, 0);
        idle(1);
        check("t5_first_dir", 64'(direct_resolved), 64'd0);
        check("t5_mp", 64'(direct_mispredict), 64'd1);

        // asynchronous reset with entries in flight
        do_reset();
        cycle(1, 32'h700, 1, 0, 0, 0, 0);
        cycle(0, 32'h0, 0, 1, 0, 1, 0);
        idle(1);
        for (int i = 0; i < 3; i++) cycle(1, 32'h710 + 32'(i), 0, 0, 0, 0, 0);
        #2 rst = 1;
        #1;
        model_reset();
        check("t6_commit", 64'(branch_commit), 64'd0);
        check("t6_pc", 64'(pc_head), 64'd0);
        check("t6_count", 64'(count), 64'd0);
        @(negedge clk);
        rst = 0;
        cycle(1, 32'h800, 1, 0, 0, 0, 0);
        check("t6_count_after", 64'(count), 64'd1);

        // random traffic
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                rt = mq[$urandom_range(0, mq.size() - 1)].tag;
            else
                rt = $urandom_range(0, DEPTH - 1);
            cycle($urandom_range(0, 99) < 55, $urandom, 1'($urandom),
                  $urandom_range(0, 99) < 50, rt, 1'($urandom),
                  $urandom_range(0, 99) < 70);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/b_resolve_queue.md
Name: b_resolve_queue

Overview:
- In-order queue of in-flight conditional branches between fetch/predict and commit.
- Fetch allocates an entry for each predicted branch (PC plus predicted direction). Execute resolves entries out of order by tag. Entries retire in program order.
- On retirement it drives the commit-side inputs of the local-history predictor: branch_commit, pc_head, direct_resolved and direct_mispredict.
- On a retired mispredict it flushes all younger (wrong-path) entries.

Parameters:
- DEPTH, 8, number of entries; power of two, minimum 2.
- TAG_W, 3, tag width; equals log2(DEPTH).
- PC_W, 32, program-counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- alloc_valid  in  1  fetch has a predicted branch this cycle.
- alloc_pc  in  PC_W  PC of that branch.
- alloc_pred  in  1  predicted direction (1 = taken).
- alloc_ready  out  1  allocation accepted this cycle (combinational).
- alloc_tag  out  TAG_W  tag given to the allocation (current tail pointer).
- res_valid  in  1  execute resolved a branch.
- res_tag  in  TAG_W  tag of the resolved branch.
- res_taken  in  1  actual direction.
- commit_en  in  1  ROB permits branch retirement this cycle.
- branch_commit  out  1  registered; one entry retired.
- pc_head  out  PC_W  registered; PC of the retired entry.
- direct_resolved  out  1  registered; actual direction of the retired entry.
- direct_mispredict  out  1  registered; retired entry was mispredicted.
- count  out  TAG_W+1  number of occupied entries.

Behaviour:
- Per-entry state: FREE, PENDING, RESOLVED. Each entry also holds pc, pred and taken.
  - FREE -> PENDING on allocate.
  - PENDING -> RESOLVED on matching res_valid.
  - RESOLVED -> FREE on retire or flush.
  - PENDING -> FREE on flush.
- Reset: head = tail = 0, count = 0, all entries FREE, all registered outputs 0, pc_head = 0.
- Allocate:
  - alloc_ready = (count != DEPTH) && !retire_mp.
  - On alloc_valid && alloc_ready: entry[tail] <= {PENDING, alloc_pc, alloc_pred}, tail advances, wrapping modulo DEPTH.
- Resolve: res_valid with entry[res_tag] PENDING sets taken <= res_taken and state RESOLVED. A resolve for a FREE or RESOLVED entry is ignored, with no state change.
- Retire condition: retire = commit_en && entry[head] == RESOLVED.
  - The state used is the registered one, so a resolve of the head retires no earlier than the following cycle.
  - At most one retire per cycle.
- Retire action:
  - head advances and entry[head] becomes FREE.
  - Next cycle: branch_commit = 1, pc_head = entry.pc, direct_resolved = entry.taken, direct_mispredict = (entry.taken != entry.pred).
  - Latency from retire decision to outputs is 1 cycle.
- Mispredict flush: retire_mp = retire && (taken != pred).
  - At the same edge all entries become FREE, tail <= head+1 and count <= 0.
  - A same-cycle allocation is refused (alloc_ready low).
  - A same-cycle resolve is discarded.
- Outputs when no retire: branch_commit = 0, direct_mispredict = 0. pc_head and direct_resolved hold their last values.
- Count: count_next = count + alloc_fire - retire, so simultaneous allocate and retire leaves it unchanged; it is 0 after a flush.
- Full: when count == DEPTH, alloc_ready is 0 even if a retire occurs the same cycle. This is deliberately conservative and keeps alloc_ready free of combinational paths from commit_en.
- Empty: head FREE, so no retire occurs.
- Reset mid-operation: asynchronous clear to reset state; in-flight entries are lost, and no retire pulse is emitted in the reset cycle.

Decomposition:
- Shared package b_pkg holds:
  - enum entry_state_t {FREE, PENDING, RESOLVED};
  - struct bq_entry_t {state, pc, pred, taken};
  - the default DEPTH and PC width constants.
- No sub-module; the block is a single module with an entry array, head/tail pointers, a count register and the registered output stage.

Test Plan:
- Reset, then allocate PC 0x100 pred 1, resolve tag 0 taken 1, commit_en = 1 -> cycle after the retire: branch_commit = 1, pc_head = 0x100, direct_resolved = 1, direct_mispredict = 0; count returns to 0.
- Allocate tags 0..2 (PCs 0x10, 0x20, 0x30), resolve 2, then 1, then 0, with commit_en held high -> retire order 0x10, 0x20, 0x30, one per cycle; no retire before tag 0 is resolved.
- Allocate 4 entries; head (pred 0) resolves taken 1 -> direct_mispredict = 1 with pc_head of the head entry; count becomes 0; an allocation in the retire cycle is refused; the next allocation gets tag head+1.
- Fill 8 entries -> alloc_ready = 0 and count = 8; a ninth alloc_valid is ignored; after one retire, alloc_ready = 1 and the next tag is the wrapped tail (0 after 7).
- Resolve with a tag of a FREE entry, and a second resolve of a RESOLVED entry with the opposite direction -> no state change; the retired direct_resolved equals the first resolution.
- Assert rst while 3 entries are pending -> outputs 0 immediately, count = 0; after release the first alloc_tag = 0.
